dec_adjust: RTL

Post-processing stage behind the 8-bit carry-chain adder of the 65C02 microcode datapath. It consumes the adder's sum, per-bit carry vector and operand sign bits, then produces the final ALU result with N/V/Z/C flags. Binary operations take one registered cycle. Decimal-mode operations (ADC/SBC with D=1) take one extra cycle for the BCD nibble correction. A valid/ready handshake on both sides lets the microcode sequencer stall on decimal operations.

---
 rtl/alu_pkg.sv | 14 +
 rtl/bcd_correct.sv | 37 +++
 rtl/dec_adjust.sv | 125 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and BCD constants for the 65C02 ALU post-adder stage.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADJ,
    HOLD
  } state_t;

  localparam logic [7:0] BCD_LO_ADJ = 8'h06;
  localparam logic [7:0] BCD_HI_ADJ = 8'h60;
  localparam logic [7:0] BCD_MAX    = 8'h99;

endpackage

// File: rtl/bcd_correct.sv
// Combinational BCD nibble correction of a binary adder sum for ADC/SBC in decimal mode.
module bcd_correct
  import alu_pkg::*;
(
  input  logic [7:0] i_sum,
  input  logic [7:0] i_carry,
  input  logic       i_sub,
  output logic [7:0] o_q,
  output logic       o_c
);

  logic       w_loAdj;
  logic       w_hiAdj;
  logic [7:0] w_loVal;
  logic [7:0] w_hiVal;
  logic       w_unusedCarry;

  // Only the half carry and the carry-out steer the correction.
  assign w_unusedCarry = ^{i_carry[6:4], i_carry[2:0]};

  always_comb begin
    if (i_sub) begin
      w_loAdj = ~i_carry[3];
      w_hiAdj = ~i_carry[7];
    end else begin
      w_loAdj = i_carry[3] | (i_sum[3:0] > 4'd9);
      w_hiAdj = i_carry[7] | (i_sum > BCD_MAX);
    end
  end

  assign w_loVal = w_loAdj ? BCD_LO_ADJ : 8'h00;
  assign w_hiVal = w_hiAdj ? BCD_HI_ADJ : 8'h00;

  assign o_q = i_sub ? (i_sum - w_loVal - w_hiVal) : (i_sum + w_loVal + w_hiVal);
  assign o_c = i_sub ? i_carry[7] : w_hiAdj;

endmodule

// File: rtl/dec_adjust.sv
// Final ALU result/flag stage: binary ops retire in one cycle, decimal ops spend an
// extra ADJ cycle for BCD correction; valid/ready on both sides.
module dec_adjust
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] R,
  input  logic [7:0] CARRY,
  input  logic       A7,
  input  logic       B7,
  input  logic       SUB,
  input  logic       D,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] Q,
  output logic       N,
  output logic       V,
  output logic       Z,
  output logic       C
);

  state_t     r_state;
  logic [7:0] r_sum;
  logic [7:0] r_carry;
  logic       r_a7;
  logic       r_b7;
  logic       r_sub;
  logic       r_d;
  logic [7:0] r_q;
  logic       r_n;
  logic       r_v;
  logic       r_z;
  logic       r_c;

  logic       w_accept;
  logic       w_liveV;
  logic       w_regV;
  logic [7:0] w_bcdQ;
  logic       w_bcdC;
  logic [7:0] w_adjQ;
  logic       w_adjC;

  assign in_ready  = (r_state == IDLE) | ((r_state == HOLD) & out_ready);
  assign out_valid = (r_state == HOLD);
  assign w_accept  = in_valid & in_ready;

  // Overflow always comes from the binary operands, even in decimal mode.
  assign w_liveV = (A7 == B7) & (R[7] != A7);
  assign w_regV  = (r_a7 == r_b7) & (r_sum[7] != r_a7);

  bcd_correct u_bcd (
    .i_sum   (r_sum),
    .i_carry (r_carry),
    .i_sub   (r_sub),
    .o_q     (w_bcdQ),
    .o_c     (w_bcdC)
  );

  assign w_adjQ = r_d ? w_bcdQ : r_sum;
  assign w_adjC = r_d ? w_bcdC : r_carry[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sum   <= '0;
      r_carry <= '0;
      r_a7    <= 1'b0;
      r_b7    <= 1'b0;
      r_sub   <= 1'b0;
      r_d     <= 1'b0;
      r_q     <= '0;
      r_n     <= 1'b0;
      r_v     <= 1'b0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sum   <= R;
        r_carry <= CARRY;
        r_a7    <= A7;
        r_b7    <= B7;
        r_sub   <= SUB;
        r_d     <= D;
      end
      unique case (r_state)
        IDLE, HOLD: begin
          // Binary results go straight to the output register so HOLD can chain with no bubble.
          if (w_accept) begin
            if (D) begin
              r_state <= ADJ;
            end else begin
              r_state <= HOLD;
              r_q     <= R;
              r_n     <= R[7];
              r_z     <= (R == 8'h00);
              r_c     <= CARRY[7];
              r_v     <= w_liveV;
            end
          end else if ((r_state == HOLD) && out_ready) begin
            r_state <= IDLE;
          end
        end
        ADJ: begin
          r_state <= HOLD;
          r_q     <= w_adjQ;
          r_n     <= w_adjQ[7];
          r_z     <= (w_adjQ == 8'h00);
          r_c     <= w_adjC;
          r_v     <= w_regV;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Q = r_q;
  assign N = r_n;
  assign V = r_v;
  assign Z = r_z;
  assign C = r_c;

endmodule
